qcl_add_sub_multiword: RTL and testbench



---
 rtl/qcl_add_sub_multiword.sv | 136 +++++++++++++
 tb/tb_qcl_add_sub_multiword.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qcl_add_sub_multiword.sv
// Sequential multi-word unsigned add/sub: one width_p slice per cycle, LSB first.
// Ports: clk_i, reset_i (sync, active-high); v_i/ready_o/a_i/b_i in; v_o/yumi_i/s_o/c_o out.
module qcl_add_sub_multiword #(
  parameter int width_p          = 8,
  parameter int els_p            = 4,
  parameter int is_add_not_sub_p = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [width_p*els_p-1:0]   a_i,
  input  logic [width_p*els_p-1:0]   b_i,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic [width_p*els_p-1:0]   s_o,
  output logic                       c_o
);

  localparam int tot_lp = width_p * els_p;
  localparam int cnt_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(els_p - 1);

  if (width_p < 1) begin : g_bad_width
    $error("width_p must be >= 1");
  end
  if (els_p < 1) begin : g_bad_els
    $error("els_p must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [tot_lp-1:0]     a_q, a_d;
  logic [tot_lp-1:0]     b_q, b_d;
  logic [tot_lp-1:0]     s_q, s_d;
  logic                  c_q, c_d;
  logic                  cy_q, cy_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;

  logic                  last;
  int                    base;
  logic [width_p-1:0]    sl_a;
  logic [width_p-1:0]    sl_b;
  logic [width_p:0]      res;

  assign last = (cnt_q == last_lp);

  // State register plus datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (v_i) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only
  always_comb begin
    ready_o = (state_q == IDLE);
    v_o     = (state_q == DONE);
  end

  // Slice datapath; res MSB is carry (add) or borrow (sub)
  always_comb begin
    base = int'(cnt_q) * width_p;
    sl_a = a_q[base +: width_p];
    sl_b = b_q[base +: width_p];
    if (is_add_not_sub_p != 0) begin
      res = {1'b0, sl_a} + {1'b0, sl_b} + {{width_p{1'b0}}, cy_q};
    end else begin
      res = {1'b0, sl_a} - {1'b0, sl_b} - {{width_p{1'b0}}, cy_q};
    end
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    c_d   = c_q;
    cy_d  = cy_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (v_i) begin
          a_d   = a_i;
          b_d   = b_i;
          cy_d  = 1'b0;
          cnt_d = '0;
        end
      end
      BUSY: begin
        s_d[base +: width_p] = res[width_p-1:0];
        cy_d = res[width_p];
        if (last) begin
          c_d   = res[width_p];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
      default: ;
    endcase
  end

  assign s_o = s_q;
  assign c_o = c_q;

endmodule

// File: tb/tb_qcl_add_sub_multiword.sv
// Directed + streaming bench for qcl_add_sub_multiword.
// DUT 0: add 8x4, DUT 1: sub 8x4, DUT 2: add 8x1.
module tb_qcl_add_sub_multiword;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  v;
  logic [2:0]  yumi;
  wire  [2:0]  rdy;
  wire  [2:0]  vo;
  wire  [2:0]  co;
  logic [31:0] a [3];
  logic [31:0] b [3];
  wire  [31:0] s0;
  wire  [31:0] s1;
  wire  [7:0]  s2;

  int n_chk = 0;
  int n_fail = 0;

  qcl_add_sub_multiword #(.width_p(8), .els_p(4), .is_add_not_sub_p(1)) dut_add (
    .clk_i(clk), .reset_i(rst), .v_i(v[0]), .ready_o(rdy[0]),
    .a_i(a[0]), .b_i(b[0]), .v_o(vo[0]), .yumi_i(yumi[0]),
    .s_o(s0), .c_o(co[0])
  );

  qcl_add_sub_multiword #(.width_p(8), .els_p(4), .is_add_not_sub_p(0)) dut_sub (
    .clk_i(clk), .reset_i(rst), .v_i(v[1]), .ready_o(rdy[1]),
    .a_i(a[1]), .b_i(b[1]), .v_o(vo[1]), .yumi_i(yumi[1]),
    .s_o(s1), .c_o(co[1])
  );

  qcl_add_sub_multiword #(.width_p(8), .els_p(1), .is_add_not_sub_p(1)) dut_one (
    .clk_i(clk), .reset_i(rst), .v_i(v[2]), .ready_o(rdy[2]),
    .a_i(a[2][7:0]), .b_i(b[2][7:0]), .v_o(vo[2]), .yumi_i(yumi[2]),
    .s_o(s2), .c_o(co[2])
  );

  function automatic logic [31:0] sget(int d);
    if (d == 0) return s0;
    if (d == 1) return s1;
    return {24'd0, s2};
  endfunction

  function automatic int nel(int d);
    return (d == 2) ? 1 : 4;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic, independent of slicing
  task automatic model(int d, logic [31:0] x, logic [31:0] y,
                       output logic [31:0] es, output logic ec);
    int w;
    logic [63:0] mask;
    logic [63:0] r;
    w = nel(d) * 8;
    mask = (64'd1 << w) - 64'd1;
    if (d == 1) begin
      r  = {32'd0, x} - {32'd0, y};
      ec = (x < y);
    end else begin
      r  = {32'd0, x} + {32'd0, y};
      ec = r[w];
    end
    es = 32'(r & mask);
  endtask

  task automatic op_start(int d, logic [31:0] x, logic [31:0] y);
    int lat;
    chk("accept_ready", rdy[d], 1);
    v[d] = 1'b1;
    a[d] = x;
    b[d] = y;
    tick;
    v[d] = 1'b0;
    lat = 1;
    while (!vo[d] && lat < 30) begin
      tick;
      lat++;
    end
    chk("latency", lat, nel(d) + 1);
  endtask

  task automatic op_res(int d, logic [31:0] es, logic ec);
    chk("s_o", sget(d), es);
    chk("c_o", co[d], ec);
  endtask

  task automatic pop(int d);
    yumi[d] = 1'b1;
    tick;
    yumi[d] = 1'b0;
    chk("pop_ready", rdy[d], 1);
    chk("pop_v_o", vo[d], 0);
  endtask

  task automatic stream(int d, int nops);
    logic [31:0] qs[$];
    logic        qc[$];
    logic [31:0] es;
    logic        ec;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] mask;
    int acc;
    int done;
    int cyc;
    int last;
    mask = (d == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    acc = 0;
    done = 0;
    cyc = 0;
    last = -1;
    v[d] = 1'b1;
    yumi[d] = 1'b1;
    while (done < nops && cyc < nops * 10 + 50) begin
      if (vo[d]) begin
        if (qs.size() == 0) begin
          chk("stream_spurious_v_o", vo[d], 0);
        end else begin
          chk("stream_s", sget(d), qs.pop_front());
          chk("stream_c", co[d], qc.pop_front());
        end
        done++;
      end
      if (rdy[d] && v[d]) begin
        if (last >= 0) chk("stream_ii", cyc - last, nel(d) + 2);
        last = cyc;
        x = $urandom & mask;
        y = $urandom & mask;
        a[d] = x;
        b[d] = y;
        model(d, x, y, es, ec);
        qs.push_back(es);
        qc.push_back(ec);
        acc++;
        if (acc >= nops) begin
          tick;
          cyc++;
          v[d] = 1'b0;
          continue;
        end
      end
      tick;
      cyc++;
    end
    chk("stream_count", done, nops);
    v[d] = 1'b0;
    yumi[d] = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    v = '0;
    yumi = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    tick;
    tick;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", rdy[i], 1);
      chk("rst_v_o", vo[i], 0);
      chk("rst_s_o", sget(i), 0);
      chk("rst_c_o", co[i], 0);
    end

    op_start(0, 32'h0000_00FF, 32'h0000_0001);
    op_res(0, 32'h0000_0100, 1'b0);
    pop(0);

    op_start(0, 32'hFFFF_FFFF, 32'h0000_0001);
    op_res(0, 32'h0000_0000, 1'b1);
    pop(0);

    op_start(0, 32'h0000_0001, 32'h0000_0001);
    op_res(0, 32'h0000_0002, 1'b0);
    pop(0);

    op_start(1, 32'h0000_0000, 32'h0000_0001);
    op_res(1, 32'hFFFF_FFFF, 1'b1);
    pop(1);

    op_start(1, 32'h1234_5678, 32'h0234_5678);
    op_res(1, 32'h1000_0000, 1'b0);
    pop(1);

    op_start(2, 32'h0000_00F0, 32'h0000_0020);
    op_res(2, 32'h0000_0010, 1'b1);
    pop(2);

    op_start(0, 32'hF000_0000, 32'h2000_0000);
    op_res(0, 32'h1000_0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      v[0] = 1'b1;
      a[0] = $urandom;
      b[0] = $urandom;
      tick;
      chk("bp_v_o", vo[0], 1);
      chk("bp_ready", rdy[0], 0);
      chk("bp_s_o", s0, 32'h1000_0000);
      chk("bp_c_o", co[0], 1);
    end
    v[0] = 1'b0;
    pop(0);
    tick;
    chk("bp_no_accept", vo[0], 0);
    chk("bp_still_idle", rdy[0], 1);

    v[0] = 1'b1;
    a[0] = 32'h1111_1111;
    b[0] = 32'h2222_2222;
    tick;
    v[0] = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_ready", rdy[0], 1);
    chk("mid_rst_v_o", vo[0], 0);
    chk("mid_rst_s_o", s0, 0);
    chk("mid_rst_c_o", co[0], 0);
    op_start(0, 32'h8000_0000, 32'h8000_0000);
    op_res(0, 32'h0000_0000, 1'b1);
    pop(0);

    stream(0, 1000);
    stream(1, 200);
    stream(2, 300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
